// File: rtl/pwm_duty_decoder_if.sv
// pwm_duty_decoder_if: bundle of the PWM decoder's input and result signals.
//   pwm_in     raw PWM waveform (asynchronous to the decoder clock)
//   duty       last decoded duty, 0..255
//   duty_valid one-cycle pulse, duty/period updated
//   period     last measured period in clock cycles
//   stuck      level, no rising edge seen for the timeout interval
//   overrun    one-cycle pulse, sample dropped
// master = waveform source / result consumer, slave = decoder.
interface pwm_duty_decoder_if #(
  parameter int CW = 20
);
  logic          pwm_in;
  logic [7:0]    duty;
  logic          duty_valid;
  logic [CW-1:0] period;
  logic          stuck;
  logic          overrun;

  modport master (output pwm_in, input duty, duty_valid, period, stuck, overrun);
  modport slave  (input pwm_in, output duty, duty_valid, period, stuck, overrun);
endinterface

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: recovers an 8-bit duty value from a PWM waveform.
// Measures high time H and period P between rising edges, then runs a
// 9-cycle restoring divide to report duty = min(floor(256*H/P), 255).
// Ports:
//   sys_clk  system clock, all logic on posedge
//   rst_n    synchronous active-low reset
//   bus      pwm_duty_decoder_if.slave (pwm_in in; duty, duty_valid,
//            period, stuck, overrun out)
module pwm_duty_decoder #(
  parameter int CW      = 20,
  parameter int TIMEOUT = 1_000_000,
  parameter int MIN_P   = 16
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  pwm_duty_decoder_if.slave bus
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] TMO     = CW'(TIMEOUT);
  localparam logic [CW-1:0] MINP    = CW'(MIN_P);

  typedef enum logic [1:0] {ARM, MEASURE, DIVIDE} state_t;

  state_t        state, nxt;
  logic          sync1, pwm_s, pwm_d, rise;
  logic [CW-1:0] cnt_p, cnt_h;
  logic [CW-1:0] lat_p, rem, diff;
  logic [CW:0]   trial;
  logic [8:0]    dsh;
  logic [7:0]    q;
  logic [8:0]    q_fin;
  logic [3:0]    bit_cnt;
  logic          ge;
  logic          latch, finish, ovr, tmo_hit;

  logic [7:0]    duty_r;
  logic [CW-1:0] period_r;
  logic          valid_r, stuck_r, ovr_r;

  // Input synchronizer plus one extra stage for edge detection.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      pwm_s <= 1'b0;
      pwm_d <= 1'b0;
    end else begin
      sync1 <= bus.pwm_in;
      pwm_s <= sync1;
      pwm_d <= pwm_s;
    end
  end

  assign rise = pwm_s & ~pwm_d;

  // Counters run in every state; a rise reloads them to 1 because the
  // rise cycle itself is the first (high) cycle of the new window.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      cnt_p <= '0;
      cnt_h <= '0;
    end else if (rise) begin
      cnt_p <= CW'(1);
      cnt_h <= CW'(1);
    end else begin
      if (tmo_hit)               cnt_p <= '0;
      else if (cnt_p != CNT_MAX) cnt_p <= cnt_p + 1'b1;
      if (pwm_s && cnt_h != CNT_MAX) cnt_h <= cnt_h + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) state <= ARM;
    else        state <= nxt;
  end

  // Rise has priority over both timeout and divide completion.
  always_comb begin
    nxt     = state;
    latch   = 1'b0;
    finish  = 1'b0;
    ovr     = 1'b0;
    tmo_hit = 1'b0;
    case (state)
      ARM: begin
        if (rise)               nxt = MEASURE;
        else if (cnt_p == TMO)  tmo_hit = 1'b1;
      end
      MEASURE: begin
        if (rise) begin
          if (cnt_p < MINP) ovr = 1'b1;
          else begin
            latch = 1'b1;
            nxt   = DIVIDE;
          end
        end else if (cnt_p == TMO) begin
          tmo_hit = 1'b1;
          nxt     = ARM;
        end
      end
      DIVIDE: begin
        if (rise) begin
          ovr = 1'b1;
          nxt = MEASURE;
        end else if (bit_cnt == 4'd8) begin
          finish = 1'b1;
          nxt    = MEASURE;
        end
      end
      default: nxt = ARM;
    endcase
  end

  // Restoring divide of {H, 8'b0} by P. Since H <= P the top CW-1 bits of
  // the dividend (H >> 1) are already below P, so only the low 9 dividend
  // bits {H[0], 8'b0} are shifted through, giving a 9-bit quotient.
  assign trial = {rem, dsh[8]};
  assign ge    = trial >= {1'b0, lat_p};
  assign diff  = trial[CW-1:0] - lat_p;   // valid only when ge; result < P
  assign q_fin = {q, ge};

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      lat_p   <= '0;
      rem     <= '0;
      dsh     <= '0;
      q       <= '0;
      bit_cnt <= '0;
    end else if (latch) begin
      lat_p   <= cnt_p;
      rem     <= cnt_h >> 1;
      dsh     <= {cnt_h[0], 8'h00};
      q       <= '0;
      bit_cnt <= '0;
    end else if (state == DIVIDE) begin
      rem     <= ge ? diff : trial[CW-1:0];
      dsh     <= {dsh[7:0], 1'b0};
      q       <= {q[6:0], ge};
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      duty_r   <= '0;
      period_r <= '0;
      valid_r  <= 1'b0;
      stuck_r  <= 1'b0;
      ovr_r    <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      ovr_r   <= ovr;
      if (finish) begin
        duty_r   <= q_fin[8] ? 8'hFF : q_fin[7:0];
        period_r <= lat_p;
        valid_r  <= 1'b1;
        stuck_r  <= 1'b0;
      end else if (tmo_hit) begin
        // Stuck input reports the static level as 0% or full-scale duty.
        duty_r   <= pwm_s ? 8'hFF : 8'h00;
        period_r <= '0;
        valid_r  <= 1'b1;
        stuck_r  <= 1'b1;
      end
    end
  end

  assign bus.duty       = duty_r;
  assign bus.period     = period_r;
  assign bus.duty_valid = valid_r;
  assign bus.stuck      = stuck_r;
  assign bus.overrun    = ovr_r;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb_pwm_duty_decoder: drives PWM pulse trains into pwm_duty_decoder and
// compares valid/overrun events against a rise-to-rise reference model.
module tb_pwm_duty_decoder;
  localparam int CW      = 20;
  localparam int TIMEOUT = 1000;
  localparam int MIN_P   = 16;

  typedef struct {
    int cyc;
    int duty;
    int per;
    int stk;
  } ev_t;

  logic sys_clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  int   both_cnt = 0;
  int   rise_q[$];
  ev_t  vq[$];
  int   oq[$];
  ev_t  exp_v[$];
  int   exp_o[$];
  ev_t  mon_e;

  pwm_duty_decoder_if #(.CW(CW)) ifc();

  pwm_duty_decoder #(.CW(CW), .TIMEOUT(TIMEOUT), .MIN_P(MIN_P)) dut (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .bus    (ifc)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (ifc.duty_valid === 1'b1) begin
      mon_e.cyc  = cyc;
      mon_e.duty = int'(ifc.duty);
      mon_e.per  = int'(ifc.period);
      mon_e.stk  = int'(ifc.stuck);
      vq.push_back(mon_e);
    end
    if (ifc.overrun === 1'b1) oq.push_back(cyc);
    if (ifc.duty_valid === 1'b1 && ifc.overrun === 1'b1) both_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic hold(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      if (i == 0 && v && ifc.pwm_in === 1'b0) rise_q.push_back(cyc);
      ifc.pwm_in = v;
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    rst_n = 1'b0;
    ifc.pwm_in = 1'b0;
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    vq.delete();
    oq.delete();
  endtask

  // Plays pulses (high hs[k], period ps[k]) then a final rise, and builds the
  // expected events. Each rise after the first closes a window: a short gap is
  // an overrun 3 cycles after the drive (2 sync + 1 register); otherwise the
  // duty appears 12 cycles after the drive (2 sync + 10), unless the next rise
  // lands within the 9 divide cycles and aborts it.
  task automatic play(input int hs[$], input int ps[$]);
    int b, n, g;
    ev_t e;
    n = hs.size();
    exp_v.delete();
    exp_o.delete();
    hold(0, 2);
    b = rise_q.size();
    for (int k = 0; k < n; k++) begin
      hold(1, hs[k]);
      hold(0, ps[k] - hs[k]);
    end
    hold(1, 20);
    for (int k = 1; k <= n; k++) begin
      g = ps[k-1];
      if (g < MIN_P) exp_o.push_back(rise_q[b+k] + 3);
      else if (!(k < n && ps[k] <= 9)) begin
        e.cyc  = rise_q[b+k] + 12;
        e.duty = (256 * hs[k-1]) / g;
        if (e.duty > 255) e.duty = 255;
        e.per  = g;
        e.stk  = 0;
        exp_v.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (ifc.duty !== 8'd0)      begin fails++; $display("FAIL rst_duty got=%0d exp=0", ifc.duty); end
    if (ifc.period !== '0)      begin fails++; $display("FAIL rst_period got=%0d exp=0", ifc.period); end
    if (ifc.duty_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b exp=0", ifc.duty_valid); end
    if (ifc.stuck !== 1'b0)     begin fails++; $display("FAIL rst_stuck got=%b exp=0", ifc.stuck); end
    if (ifc.overrun !== 1'b0)   begin fails++; $display("FAIL rst_overrun got=%b exp=0", ifc.overrun); end
  endtask

  task automatic test_basic();
    int hs[$], ps[$];
    do_reset();
    hs = {64, 64, 64, 64};
    ps = {256, 256, 256, 256};
    play(hs, ps);
    checks++;
    if (vq.size() != exp_v.size()) begin fails++; $display("FAIL basic_count got=%0d exp=%0d", vq.size(), exp_v.size()); end
    foreach (exp_v[i]) if (i < vq.size()) begin
      checks++;
      if (vq[i].cyc != exp_v[i].cyc || vq[i].duty != exp_v[i].duty || vq[i].per != exp_v[i].per) begin
        fails++;
        $display("FAIL basic_ev%0d got cyc=%0d duty=%0d per=%0d exp cyc=%0d duty=%0d per=%0d",
                 i, vq[i].cyc, vq[i].duty, vq[i].per, exp_v[i].cyc, exp_v[i].duty, exp_v[i].per);
      end
    end
    repeat (30) @(negedge sys_clk);
    checks += 2;
    if (ifc.duty !== 8'd64)    begin fails++; $display("FAIL basic_hold_duty got=%0d exp=64", ifc.duty); end
    if (ifc.period !== CW'(256)) begin fails++; $display("FAIL basic_hold_period got=%0d exp=256", ifc.period); end
  endtask

  task automatic test_ratios();
    int hs[$], ps[$];
    do_reset();
    hs = {25, 99, 1};
    ps = {100, 100, 256};
    play(hs, ps);
    checks++;
    if (vq.size() != exp_v.size()) begin fails++; $display("FAIL ratio_count got=%0d exp=%0d", vq.size(), exp_v.size()); end
    foreach (exp_v[i]) if (i < vq.size()) begin
      checks++;
      if (vq[i].cyc != exp_v[i].cyc || vq[i].duty != exp_v[i].duty || vq[i].per != exp_v[i].per) begin
        fails++;
        $display("FAIL ratio_ev%0d got cyc=%0d duty=%0d per=%0d exp cyc=%0d duty=%0d per=%0d",
                 i, vq[i].cyc, vq[i].duty, vq[i].per, exp_v[i].cyc, exp_v[i].duty, exp_v[i].per);
      end
    end
  endtask

  task automatic test_timeout();
    int n0, d, hs[$], ps[$];
    do_reset();
    hold(0, 3100);
    checks++;
    if (vq.size() != 3) begin fails++; $display("FAIL tmo_low_count got=%0d exp=3", vq.size()); end
    foreach (vq[i]) begin
      checks++;
      if (vq[i].duty != 0 || vq[i].per != 0 || vq[i].stk != 1) begin
        fails++;
        $display("FAIL tmo_low_ev%0d got duty=%0d per=%0d stuck=%0d exp 0/0/1", i, vq[i].duty, vq[i].per, vq[i].stk);
      end
      if (i > 0) begin
        // counter restarts from zero after each timeout, allow one cycle
        d = vq[i].cyc - vq[i-1].cyc;
        checks++;
        if (d != TIMEOUT && d != TIMEOUT + 1) begin
          fails++; $display("FAIL tmo_interval%0d got=%0d exp=%0d", i, d, TIMEOUT);
        end
      end
    end
    checks++;
    if (ifc.stuck !== 1'b1) begin fails++; $display("FAIL tmo_stuck_level got=%b exp=1", ifc.stuck); end
    n0 = vq.size();
    hold(1, 2100);
    checks++;
    if (vq.size() - n0 != 2) begin fails++; $display("FAIL tmo_high_count got=%0d exp=2", vq.size() - n0); end
    for (int i = n0; i < vq.size(); i++) begin
      checks++;
      if (vq[i].duty != 255 || vq[i].per != 0 || vq[i].stk != 1) begin
        fails++;
        $display("FAIL tmo_high_ev%0d got duty=%0d per=%0d stuck=%0d exp 255/0/1", i, vq[i].duty, vq[i].per, vq[i].stk);
      end
    end
    hs = {64, 64};
    ps = {256, 256};
    n0 = vq.size();
    play(hs, ps);
    checks += 2;
    if (vq.size() - n0 != 2 || vq[vq.size()-1].duty != 64 || vq[vq.size()-1].stk != 0) begin
      fails++;
      $display("FAIL tmo_recover got n=%0d duty=%0d stuck=%0d exp n=2 duty=64 stuck=0",
               vq.size() - n0, vq[vq.size()-1].duty, vq[vq.size()-1].stk);
    end
    if (ifc.stuck !== 1'b0) begin fails++; $display("FAIL tmo_clear got=%b exp=0", ifc.stuck); end
  endtask

  task automatic test_overrun();
    int hs[$], ps[$];
    do_reset();
    hs = {64, 64, 2, 2, 2, 2, 2, 2};
    ps = {256, 256, 5, 5, 5, 5, 5, 5};
    play(hs, ps);
    checks += 2;
    if (vq.size() != exp_v.size() || (vq.size() > 0 && vq[0].cyc != exp_v[0].cyc)) begin
      fails++; $display("FAIL ovr_valid got n=%0d exp n=%0d", vq.size(), exp_v.size());
    end
    if (oq.size() != exp_o.size()) begin fails++; $display("FAIL ovr_count got=%0d exp=%0d", oq.size(), exp_o.size()); end
    foreach (exp_o[i]) if (i < oq.size()) begin
      checks++;
      if (oq[i] != exp_o[i]) begin fails++; $display("FAIL ovr_ev%0d got cyc=%0d exp cyc=%0d", i, oq[i], exp_o[i]); end
    end
    checks++;
    if (ifc.duty !== 8'd64) begin fails++; $display("FAIL ovr_duty_held got=%0d exp=64", ifc.duty); end
  endtask

  task automatic test_divide_abort();
    int hs[$], ps[$];
    do_reset();
    hs = {10, 5, 3, 128, 100};
    ps = {256, 20, 6, 256, 256};
    play(hs, ps);
    checks += 2;
    if (vq.size() != exp_v.size()) begin fails++; $display("FAIL abort_count got=%0d exp=%0d", vq.size(), exp_v.size()); end
    if (oq.size() != exp_o.size() || (oq.size() > 0 && oq[0] != exp_o[0])) begin
      fails++; $display("FAIL abort_overrun got n=%0d exp n=%0d", oq.size(), exp_o.size());
    end
    foreach (exp_v[i]) if (i < vq.size()) begin
      checks++;
      if (vq[i].cyc != exp_v[i].cyc || vq[i].duty != exp_v[i].duty || vq[i].per != exp_v[i].per) begin
        fails++;
        $display("FAIL abort_ev%0d got cyc=%0d duty=%0d per=%0d exp cyc=%0d duty=%0d per=%0d",
                 i, vq[i].cyc, vq[i].duty, vq[i].per, exp_v[i].cyc, exp_v[i].duty, exp_v[i].per);
      end
    end
  endtask

  task automatic test_reset_mid_divide();
    do_reset();
    hold(0, 2);
    hold(1, 64); hold(0, 192);
    hold(1, 64); hold(0, 192);
    hold(1, 5);                  // third rise, decoder now mid-divide
    @(negedge sys_clk);
    rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    checks += 6;
    if (vq.size() != 1)          begin fails++; $display("FAIL rdiv_valid_count got=%0d exp=1", vq.size()); end
    if (ifc.duty !== 8'd0)       begin fails++; $display("FAIL rdiv_duty got=%0d exp=0", ifc.duty); end
    if (ifc.period !== '0)       begin fails++; $display("FAIL rdiv_period got=%0d exp=0", ifc.period); end
    if (ifc.duty_valid !== 1'b0) begin fails++; $display("FAIL rdiv_valid got=%b exp=0", ifc.duty_valid); end
    if (ifc.stuck !== 1'b0)      begin fails++; $display("FAIL rdiv_stuck got=%b exp=0", ifc.stuck); end
    if (ifc.overrun !== 1'b0)    begin fails++; $display("FAIL rdiv_overrun got=%b exp=0", ifc.overrun); end
    rst_n = 1'b1;                // pwm_in still high: first post-reset rise arms only
    hold(1, 30);
    checks++;
    if (vq.size() != 1 || oq.size() != 0) begin
      fails++; $display("FAIL rdiv_first_rise got valid=%0d ovr=%0d exp valid=1 ovr=0", vq.size(), oq.size());
    end
  endtask

  task automatic test_random();
    int hs[$], ps[$], p;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 4) == 0) p = $urandom_range(4, 15);
      else                           p = $urandom_range(16, 400);
      ps.push_back(p);
      hs.push_back($urandom_range(1, p - 1));
    end
    play(hs, ps);
    checks += 3;
    if (vq.size() != exp_v.size()) begin fails++; $display("FAIL rnd_count got=%0d exp=%0d", vq.size(), exp_v.size()); end
    if (oq.size() != exp_o.size()) begin fails++; $display("FAIL rnd_ovr_count got=%0d exp=%0d", oq.size(), exp_o.size()); end
    if (both_cnt != 0) begin fails++; $display("FAIL valid_and_overrun got=%0d exp=0", both_cnt); end
    foreach (exp_v[i]) if (i < vq.size()) begin
      checks++;
      if (vq[i].cyc != exp_v[i].cyc || vq[i].duty != exp_v[i].duty || vq[i].per != exp_v[i].per) begin
        fails++;
        $display("FAIL rnd_ev%0d got cyc=%0d duty=%0d per=%0d exp cyc=%0d duty=%0d per=%0d",
                 i, vq[i].cyc, vq[i].duty, vq[i].per, exp_v[i].cyc, exp_v[i].duty, exp_v[i].per);
      end
    end
    foreach (exp_o[i]) if (i < oq.size()) begin
      checks++;
      if (oq[i] != exp_o[i]) begin fails++; $display("FAIL rnd_ovr%0d got cyc=%0d exp cyc=%0d", i, oq[i], exp_o[i]); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ifc.pwm_in = 1'b0;
    test_reset();
    test_basic();
    test_ratios();
    test_timeout();
    test_overrun();
    test_divide_abort();
    test_reset_mid_divide();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
